// File: rtl/ramxfer_patgen_if.sv
// Pipe-side handshake bundle between the pattern engine and the SDRAM transfer block.
// master = pattern engine (drives strobes and write data), slave = transfer block.
interface ramxfer_patgen_if;
  logic        wr_ready;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_en;
  logic [15:0] rd_data;

  modport master (
    input  wr_ready, rd_valid, rd_data,
    output wr_en, wr_data, rd_en
  );

  modport slave (
    output wr_ready, rd_valid, rd_data,
    input  wr_en, wr_data, rd_en
  );
endinterface

// File: rtl/ramxfer_patgen.sv
// LFSR test-pattern engine: write pass streams a seeded LFSR into Pipe In, read pass checks Pipe Out.
// Define RAMXFER_PATGEN_ERRLOG_EN to build the first-error log (err_valid/err_index/err_expected/err_actual).
module ramxfer_patgen #(
  parameter int CNT_W = 24,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] word_count,
  ramxfer_patgen_if.master pipe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_done,
  output logic [ERR_W-1:0] err_count,
  output logic             err_valid,
  output logic [CNT_W-1:0] err_index,
  output logic [15:0]      err_expected,
  output logic [15:0]      err_actual
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t           state_reg;
  logic [31:0]      lfsr_reg;
  logic [31:0]      lfsr_next;
  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] issued_reg;
  logic [CNT_W-1:0] words_done_reg;
  logic [ERR_W-1:0] err_count_reg;
  logic             cmp_valid_reg;
  logic [15:0]      cmp_expected_reg;
  logic             more;
  logic             wr_fire;
  logic             rd_fire;
  logic             mismatch;

  assign lfsr_next = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};
  assign more      = issued_reg < target_reg;
  assign wr_fire   = (state_reg == WRITE) && !abort && pipe.wr_ready && more;
  assign rd_fire   = (state_reg == READ)  && !abort && pipe.rd_valid && more;
  assign mismatch  = cmp_valid_reg && (pipe.rd_data != cmp_expected_reg);

  assign pipe.wr_en   = wr_fire;
  assign pipe.rd_en   = rd_fire;
  assign pipe.wr_data = (state_reg == WRITE) ? lfsr_reg[15:0] : 16'h0000;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign words_done   = words_done_reg;
  assign err_count    = err_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      lfsr_reg         <= 32'h0000_0001;
      target_reg       <= '0;
      issued_reg       <= '0;
      words_done_reg   <= '0;
      err_count_reg    <= '0;
      cmp_valid_reg    <= 1'b0;
      cmp_expected_reg <= 16'h0000;
    end else if (abort) begin
      // In-flight compare is dropped; counters keep their values.
      state_reg     <= IDLE;
      cmp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cmp_valid_reg <= 1'b0;
          if (start) begin
            state_reg      <= mode ? READ : WRITE;
            lfsr_reg       <= (seed == 32'h0) ? 32'h0000_0001 : seed;
            target_reg     <= word_count;
            issued_reg     <= '0;
            words_done_reg <= '0;
            err_count_reg  <= '0;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            lfsr_reg       <= lfsr_next;
            issued_reg     <= issued_reg + CNT_W'(1);
            words_done_reg <= words_done_reg + CNT_W'(1);
          end
          if ((issued_reg == target_reg) || (wr_fire && (issued_reg + CNT_W'(1) == target_reg)))
            state_reg <= DONE;
        end
        READ: begin
          cmp_valid_reg <= rd_fire;
          if (rd_fire) begin
            lfsr_reg         <= lfsr_next;
            issued_reg       <= issued_reg + CNT_W'(1);
            cmp_expected_reg <= lfsr_reg[15:0];
          end
          if (cmp_valid_reg) begin
            words_done_reg <= words_done_reg + CNT_W'(1);
            if (mismatch && (err_count_reg != {ERR_W{1'b1}}))
              err_count_reg <= err_count_reg + ERR_W'(1);
          end
          // Once everything is issued, the compare in this cycle (if any) is the last one.
          if (issued_reg == target_reg)
            state_reg <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef RAMXFER_PATGEN_ERRLOG_EN
  logic             err_valid_reg;
  logic [CNT_W-1:0] err_index_reg;
  logic [15:0]      err_expected_reg;
  logic [15:0]      err_actual_reg;

  // words_done_reg counts completed compares, so it is the index of the word under compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid_reg    <= 1'b0;
      err_index_reg    <= '0;
      err_expected_reg <= 16'h0000;
      err_actual_reg   <= 16'h0000;
    end else if (!abort) begin
      if ((state_reg == IDLE) && start) begin
        err_valid_reg    <= 1'b0;
        err_index_reg    <= '0;
        err_expected_reg <= 16'h0000;
        err_actual_reg   <= 16'h0000;
      end else if ((state_reg == READ) && mismatch && !err_valid_reg) begin
        err_valid_reg    <= 1'b1;
        err_index_reg    <= words_done_reg;
        err_expected_reg <= cmp_expected_reg;
        err_actual_reg   <= pipe.rd_data;
      end
    end
  end

  assign err_valid    = err_valid_reg;
  assign err_index    = err_index_reg;
  assign err_expected = err_expected_reg;
  assign err_actual   = err_actual_reg;
`else
  assign err_valid    = 1'b0;
  assign err_index    = '0;
  assign err_expected = 16'h0000;
  assign err_actual   = 16'h0000;
`endif

endmodule

// File: tb/tb_ramxfer_patgen.sv
// Directed self-checking bench for ramxfer_patgen: write/read passes, stalls, errors, abort and reset.
module tb_ramxfer_patgen;
  localparam int CNT_W = 24;
  localparam int ERR_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      seed = 32'h0;
  logic [CNT_W-1:0] word_count = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] words_done;
  logic [ERR_W-1:0] err_count;
  logic             err_valid;
  logic [CNT_W-1:0] err_index;
  logic [15:0]      err_expected;
  logic [15:0]      err_actual;

  ramxfer_patgen_if pipe_if();

  ramxfer_patgen #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .abort        (abort),
    .seed         (seed),
    .word_count   (word_count),
    .pipe         (pipe_if),
    .busy         (busy),
    .done         (done),
    .words_done   (words_done),
    .err_count    (err_count),
    .err_valid    (err_valid),
    .err_index    (err_index),
    .err_expected (err_expected),
    .err_actual   (err_actual)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_seq [0:6] = '{16'h0001, 16'h0003, 16'h0006, 16'h000D, 16'h001B, 16'h0036, 16'h006D};
  logic [15:0] golden [$];
  logic [15:0] fifo [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic m, input logic [31:0] s, input logic [CNT_W-1:0] n);
    start = 1'b1; mode = m; seed = s; word_count = n;
    tick();
    start = 1'b0;
  endtask

  // Stimulus driver: runs a write pass with wr_ready held high, capturing written words.
  task automatic do_write_capture(input int n, input int limit, output bit saw_done);
    saw_done = 1'b0;
    pipe_if.wr_ready = 1'b1;
    pulse_start(1'b0, 32'h1, CNT_W'(n));
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (pipe_if.wr_en) golden.push_back(pipe_if.wr_data);
      if (done) begin saw_done = 1'b1; tick(); break; end
      tick();
    end
  endtask

  // Stimulus driver: runs a read pass fed from the model FIFO; returns the cycle index of done.
  task automatic do_read(input int n, input int limit, output int done_cycle, output bit saw_done);
    logic fire;
    saw_done = 1'b0;
    done_cycle = -1;
    pipe_if.rd_valid = (fifo.size() > 0);
    pulse_start(1'b1, 32'h1, CNT_W'(n));
    for (int k = 0; k < limit; k++) begin
      pipe_if.rd_valid = (fifo.size() > 0);
      @(negedge clk);
      fire = pipe_if.rd_en;
      if (done) begin saw_done = 1'b1; done_cycle = k; end
      tick();
      if (fire) pipe_if.rd_data = fifo.pop_front();
      if (saw_done) break;
    end
    pipe_if.rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if ({pipe_if.wr_en, pipe_if.rd_en} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b want=00", {pipe_if.wr_en, pipe_if.rd_en}); end
    checks++; if (pipe_if.wr_data !== 16'h0) begin failures++; $display("FAIL reset_wr_data got=%h want=0000", pipe_if.wr_data); end
    checks++; if (words_done !== '0 || err_count !== '0) begin failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", words_done, err_count); end
    checks++; if ({err_valid, err_index, err_expected, err_actual} !== '0) begin failures++; $display("FAIL reset_errlog got=%0b/%0d/%h/%h want=0", err_valid, err_index, err_expected, err_actual); end
    tick();
    reset = 1'b0;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_write4();
    pipe_if.wr_ready = 1'b1;
    pulse_start(1'b0, 32'h1, CNT_W'(4));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++; if (pipe_if.wr_en !== 1'b1) begin failures++; $display("FAIL w4_wr_en[%0d] got=%0b want=1", k, pipe_if.wr_en); end
        checks++; if (pipe_if.wr_data !== exp_seq[k]) begin failures++; $display("FAIL w4_data[%0d] got=%h want=%h", k, pipe_if.wr_data, exp_seq[k]); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL w4_early_done[%0d] got=%0b want=0", k, done); end
      end else begin
        checks++; if (pipe_if.wr_en !== 1'b0) begin failures++; $display("FAIL w4_extra_wr_en got=%0b want=0", pipe_if.wr_en); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL w4_done got=%0b want=1", done); end
        checks++; if (words_done !== CNT_W'(4)) begin failures++; $display("FAIL w4_words_done got=%0d want=4", words_done); end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL w4_idle got busy=%0b done=%0b want=0/0", busy, done); end
    checks++; if (words_done !== CNT_W'(4)) begin failures++; $display("FAIL w4_hold got=%0d want=4", words_done); end
    tick();
    $display("test_write4: words_done=%0d", words_done);
  endtask

  task automatic test_stall_seed0();
    int got = 0;
    int last_fire = -10;
    bit saw_done = 1'b0;
    bit bad_stall = 1'b0;
    pipe_if.wr_ready = 1'b1;
    pulse_start(1'b0, 32'h0, CNT_W'(6));
    for (int k = 0; k < 40; k++) begin
      pipe_if.wr_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(negedge clk);
      if (!pipe_if.wr_ready && pipe_if.wr_en) bad_stall = 1'b1;
      if (pipe_if.wr_en) begin
        checks++; if (got > 5 || pipe_if.wr_data !== exp_seq[got]) begin failures++; $display("FAIL stall_data[%0d] got=%h want=%h", got, pipe_if.wr_data, exp_seq[got % 7]); end
        got++;
        last_fire = k;
      end
      if (done) begin
        saw_done = 1'b1;
        checks++; if (k !== last_fire + 1) begin failures++; $display("FAIL stall_done_cycle got=%0d want=%0d", k, last_fire + 1); end
        tick();
        break;
      end
      tick();
    end
    pipe_if.wr_ready = 1'b1;
    checks++; if (!saw_done) begin failures++; $display("FAIL stall_timeout got=no_done want=done"); end
    checks++; if (bad_stall) begin failures++; $display("FAIL stall_wr_en got=strobe_while_not_ready want=none"); end
    checks++; if (got !== 6 || words_done !== CNT_W'(6)) begin failures++; $display("FAIL stall_count got=%0d/%0d want=6/6", got, words_done); end
    $display("test_stall_seed0: words=%0d", got);
  endtask

  task automatic test_zero_count();
    for (int m = 0; m < 2; m++) begin
      bit strobe = 1'b0;
      pipe_if.wr_ready = 1'b1;
      pipe_if.rd_valid = 1'b1;
      pulse_start(m[0], 32'h1, '0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (pipe_if.wr_en || pipe_if.rd_en) strobe = 1'b1;
        if (k == 0) begin
          checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL zero_c1[m%0d] got done=%0b busy=%0b want=0/1", m, done, busy); end
        end else if (k == 1) begin
          checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done[m%0d] got=%0b want=1", m, done); end
        end
        tick();
      end
      pipe_if.rd_valid = 1'b0;
      checks++; if (strobe) begin failures++; $display("FAIL zero_strobe[m%0d] got=strobe want=none", m); end
      checks++; if (words_done !== '0) begin failures++; $display("FAIL zero_words[m%0d] got=%0d want=0", m, words_done); end
      $display("test_zero_count: mode=%0d", m);
    end
  endtask

  task automatic test_loopback();
    bit saw_done;
    int dc;
    golden.delete();
    do_write_capture(2048, 2100, saw_done);
    checks++; if (!saw_done || golden.size() !== 2048) begin failures++; $display("FAIL loop_write got=%0d/%0b want=2048/1", golden.size(), saw_done); end
    checks++; if (golden.size() < 4 || golden[3] !== 16'h000D) begin failures++; $display("FAIL loop_write_word3 got=%h want=000d", (golden.size() > 3) ? golden[3] : 16'hxxxx); end
    fifo = golden;
    do_read(2048, 2100, dc, saw_done);
    checks++; if (!saw_done || dc !== 2049) begin failures++; $display("FAIL loop_done got=%0d want=2049", dc); end
    checks++; if (err_count !== '0) begin failures++; $display("FAIL loop_errs got=%0d want=0", err_count); end
    checks++; if (words_done !== CNT_W'(2048)) begin failures++; $display("FAIL loop_words got=%0d want=2048", words_done); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL loop_err_valid got=%0b want=0", err_valid); end
    $display("test_loopback: words=%0d errs=%0d", words_done, err_count);
  endtask

  task automatic test_corrupt();
    bit saw_done;
    int dc;
    fifo = '{16'h0001, 16'h0003, 16'h0000, 16'h000D};
    do_read(4, 20, dc, saw_done);
    checks++; if (!saw_done || dc !== 5) begin failures++; $display("FAIL corrupt_done got=%0d want=5", dc); end
    checks++; if (err_count !== ERR_W'(1)) begin failures++; $display("FAIL corrupt_errs got=%0d want=1", err_count); end
    checks++; if (words_done !== CNT_W'(4)) begin failures++; $display("FAIL corrupt_words got=%0d want=4", words_done); end
`ifdef RAMXFER_PATGEN_ERRLOG_EN
    checks++; if (err_valid !== 1'b1 || err_index !== CNT_W'(2)) begin failures++; $display("FAIL corrupt_log got=%0b/%0d want=1/2", err_valid, err_index); end
    checks++; if (err_expected !== 16'h0006 || err_actual !== 16'h0000) begin failures++; $display("FAIL corrupt_log_data got=%h/%h want=0006/0000", err_expected, err_actual); end
`else
    checks++; if ({err_valid, err_index, err_expected, err_actual} !== '0) begin failures++; $display("FAIL corrupt_nolog got=%0b/%0d/%h/%h want=0", err_valid, err_index, err_expected, err_actual); end
`endif
    $display("test_corrupt: errs=%0d", err_count);
  endtask

  task automatic test_abort_reset();
    int fires = 0;
    bit fire;
    bit bad = 1'b0;
    fifo = golden;
    pipe_if.rd_valid = 1'b1;
    pulse_start(1'b1, 32'h1, CNT_W'(1000));
    for (int k = 0; k < 300; k++) begin
      pipe_if.rd_valid = 1'b1;
      abort = (fires == 99);
      @(negedge clk);
      fire = pipe_if.rd_en;
      if (abort) begin
        checks++; if (pipe_if.rd_en !== 1'b0) begin failures++; $display("FAIL abort_rd_en got=%0b want=0", pipe_if.rd_en); end
      end
      tick();
      if (fire) begin pipe_if.rd_data = fifo.pop_front(); fires++; end
      if (abort) break;
    end
    abort = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || busy || pipe_if.rd_en) bad = 1'b1;
      tick();
    end
    pipe_if.rd_valid = 1'b0;
    checks++; if (bad) begin failures++; $display("FAIL abort_idle got=activity want=idle"); end
    checks++; if (words_done !== CNT_W'(98) || err_count !== '0) begin failures++; $display("FAIL abort_counters got=%0d/%0d want=98/0", words_done, err_count); end
    $display("test_abort: fires=%0d words_done=%0d", fires, words_done);

    pipe_if.wr_ready = 1'b1;
    pulse_start(1'b0, 32'h1, CNT_W'(50));
    for (int k = 0; k < 10; k++) tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pipe_if.wr_en !== 1'b0) begin failures++; $display("FAIL rst_ctrl got=%0b/%0b/%0b want=0/0/0", busy, done, pipe_if.wr_en); end
    checks++; if (pipe_if.wr_data !== 16'h0 || words_done !== '0 || err_count !== '0) begin failures++; $display("FAIL rst_data got=%h/%0d/%0d want=0", pipe_if.wr_data, words_done, err_count); end
    tick(); tick();
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done || pipe_if.wr_en) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin failures++; $display("FAIL rst_no_done got=activity want=idle"); end
    $display("test_abort_reset: reset mid-write");
  endtask

  initial begin
    pipe_if.wr_ready = 1'b0;
    pipe_if.rd_valid = 1'b0;
    pipe_if.rd_data  = 16'h0000;
    test_reset();
    test_write4();
    test_stall_seed0();
    test_zero_count();
    test_loopback();
    test_corrupt();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
